// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default geometry and read-side output buffer state encoding.
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 8;
  localparam int FIFO_ADDR_WIDTH = 3;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2
  } buf_state_e;

  function automatic logic [1:0] occupancy(input buf_state_e s);
    case (s)
      S1:      return 2'd1;
      S2:      return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/rd_fwft_ctrl_if.sv
// Read-side FIFO bundle: pointer exchange with rd_ptr_logic, RAM read port and FWFT consumer handshake.
interface rd_fwft_ctrl_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) ();

  logic                  empty;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [ADDR_WIDTH:0]   g_rd_ptr;
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  dout_ready;

  modport master (
    input  empty, mem_rd_data, dout_ready,
    output rd_ptr, g_rd_ptr, mem_rd_en, mem_rd_addr, dout, dout_valid
  );

  modport slave (
    output empty, mem_rd_data, dout_ready,
    input  rd_ptr, g_rd_ptr, mem_rd_en, mem_rd_addr, dout, dout_valid
  );

endinterface

// File: rtl/b2g.sv
// Combinational binary-to-Gray converter, counterpart of g2b.
module b2g #(
  parameter int W = 4
) (
  input  logic [W-1:0] bin_i,
  output logic [W-1:0] gray_o
);

  assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/rd_fwft_ctrl.sv
// Read-domain FIFO controller: RAM fetch, binary/Gray read pointers and a 2-entry FWFT output buffer.
module rd_fwft_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic           clk_B,
  input  logic           rst,
  rd_fwft_ctrl_if.master bus
);

  localparam int PW = ADDR_WIDTH + 1;

  buf_state_e            state_q, state_d;
  logic                  inflight_q;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_inc;
  logic [PW-1:0]         g_rd_ptr_q, g_rd_ptr_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  valid, pop, fetch;
  logic [2:0]            occ_after;
  logic [1:0]            held_after;

  assign rd_ptr_inc = rd_ptr_q + PW'(1);

  b2g #(.W(PW)) u_b2g (
    .bin_i  (rd_ptr_inc),
    .gray_o (g_rd_ptr_d)
  );

  // Output/control decode; fetch only if the word will still fit after this cycle's pop.
  always_comb begin
    valid      = (state_q != S0);
    pop        = valid & bus.dout_ready;
    held_after = occupancy(state_q) - {1'b0, pop};
    occ_after  = {1'b0, held_after} + {2'b0, inflight_q};
    fetch      = !bus.empty && (occ_after < 3'd2);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S0: if (inflight_q) state_d = S1;
      S1: begin
        if (inflight_q && !pop)      state_d = S2;
        else if (pop && !inflight_q) state_d = S0;
      end
      S2: if (pop && !inflight_q) state_d = S1;
      default: state_d = S0;
    endcase
  end

  // Arriving word lands in the head only when the buffer is empty after this cycle's pop.
  always_comb begin
    head_d = head_q;
    skid_d = skid_q;
    if (pop) head_d = skid_q;
    if (inflight_q) begin
      if (held_after == 2'd0) head_d = bus.mem_rd_data;
      else                    skid_d = bus.mem_rd_data;
    end
  end

  always_ff @(posedge clk_B or posedge rst) begin
    if (rst) begin
      state_q    <= S0;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      g_rd_ptr_q <= '0;
      head_q     <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= fetch;
      head_q     <= head_d;
      if (fetch) begin
        rd_ptr_q   <= rd_ptr_inc;
        g_rd_ptr_q <= g_rd_ptr_d;
      end
    end
  end

  always_ff @(posedge clk_B) begin
    skid_q <= skid_d;
  end

  assign bus.rd_ptr      = rd_ptr_q;
  assign bus.g_rd_ptr    = g_rd_ptr_q;
  assign bus.mem_rd_en   = fetch;
  assign bus.mem_rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];
  assign bus.dout        = head_q;
  assign bus.dout_valid  = valid;

  a_no_overflow: assert property (@(posedge clk_B) disable iff (rst)
    !(state_q == S2 && inflight_q && !pop));

endmodule

// File: tb/tb_rd_fwft_ctrl.sv
// Bench for rd_fwft_ctrl: models RAM and write side, scoreboards the FWFT output stream.
module tb_rd_fwft_ctrl;

  logic clk_B = 1'b0;
  logic rst   = 1'b0;
  always #5 clk_B = ~clk_B;

  rd_fwft_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();

  rd_fwft_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
    .clk_B (clk_B),
    .rst   (rst),
    .bus   (bus.master)
  );

  logic [7:0] ram [8];
  logic [3:0] wr_ptr = 4'd0;
  logic [7:0] exp_q [$];
  int checks   = 0;
  int failures = 0;
  int pop_cnt  = 0;
  int fetch_cnt = 0;
  logic wrap_seen = 1'b0;

  logic [3:0] prev_g, prev_rd;
  logic       prev_hold;
  logic [7:0] prev_dout;

  assign bus.empty = (bus.rd_ptr == wr_ptr);

  always @(posedge clk_B) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= ram[bus.mem_rd_addr];
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  function automatic logic full();
    logic [3:0] d;
    d = wr_ptr - bus.rd_ptr;
    return d[3];
  endfunction

  task automatic step();
    @(posedge clk_B);
    #2;
  endtask

  task automatic write_words(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      ram[wr_ptr[2:0]] = base + 8'(i);
      exp_q.push_back(base + 8'(i));
      wr_ptr = wr_ptr + 4'd1;
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk_B) begin
    if (rst) begin
      prev_g    = 4'd0;
      prev_rd   = 4'd0;
      prev_hold = 1'b0;
      prev_dout = 8'd0;
    end else begin
      chk("g_is_gray", 32'(bus.g_rd_ptr), 32'(bus.rd_ptr ^ (bus.rd_ptr >> 1)));
      chk("g_one_bit", 32'($countones(bus.g_rd_ptr ^ prev_g) <= 1), 32'd1);
      chk("rd_addr", 32'(bus.mem_rd_addr), 32'(bus.rd_ptr[2:0]));
      if (prev_hold) chk("dout_stable", 32'(bus.dout), 32'(prev_dout));
      if (prev_rd == 4'd15 && bus.rd_ptr == 4'd0) begin
        wrap_seen = 1'b1;
        chk("wrap_g", 32'({prev_g, bus.g_rd_ptr}), 32'h80);
      end
      if (bus.mem_rd_en) fetch_cnt++;
      if (bus.dout_valid && bus.dout_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=%0h required=none", bus.dout);
        end else begin
          chk("data", 32'(bus.dout), 32'(exp_q.pop_front()));
        end
      end
      prev_hold = bus.dout_valid & !bus.dout_ready;
      prev_dout = bus.dout;
      prev_g    = bus.g_rd_ptr;
      prev_rd   = bus.rd_ptr;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, f0, cnt, words, cycles;
    bus.dout_ready = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk_B);
    #2;
    chk("rst_valid", 32'(bus.dout_valid), 32'd0);
    chk("rst_dout", 32'(bus.dout), 32'd0);
    chk("rst_rd_en", 32'(bus.mem_rd_en), 32'd0);
    rst = 1'b0;

    // Idle with empty high
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_B);
      chk("idle_rd_en", 32'(bus.mem_rd_en), 32'd0);
      chk("idle_valid", 32'(bus.dout_valid), 32'd0);
      chk("idle_rd_ptr", 32'(bus.rd_ptr), 32'd0);
      chk("idle_g_ptr", 32'(bus.g_rd_ptr), 32'd0);
    end

    // Three words, ready high: latency and back-to-back delivery
    step();
    bus.dout_ready = 1'b1;
    p0 = pop_cnt;
    write_words(3, 8'hA1);
    @(negedge clk_B);
    chk("lat_fetch", 32'(bus.mem_rd_en), 32'd1);
    chk("lat_valid0", 32'(bus.dout_valid), 32'd0);
    @(negedge clk_B);
    chk("lat_valid1", 32'(bus.dout_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_B);
      chk("burst3_valid", 32'(bus.dout_valid), 32'd1);
    end
    @(negedge clk_B);
    chk("burst3_done", 32'(bus.dout_valid), 32'd0);
    chk("burst3_pops", 32'(pop_cnt - p0), 32'd3);
    chk("burst3_rd_ptr", 32'(bus.rd_ptr), 32'd3);
    chk("burst3_g_ptr", 32'(bus.g_rd_ptr), 32'b0010);

    // Fill 8 with ready low: only two fetches, head held
    step();
    bus.dout_ready = 1'b0;
    f0 = fetch_cnt;
    write_words(8, 8'hB0);
    repeat (10) @(negedge clk_B);
    chk("fill_fetches", 32'(fetch_cnt - f0), 32'd2);
    chk("fill_rd_en", 32'(bus.mem_rd_en), 32'd0);
    chk("fill_valid", 32'(bus.dout_valid), 32'd1);
    chk("fill_head", 32'(bus.dout), 32'hB0);
    step();
    bus.dout_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_B);
      if (bus.dout_valid) cnt++;
    end
    chk("drain_no_gap", 32'(cnt), 32'd8);
    @(negedge clk_B);
    chk("drain_done", 32'(bus.dout_valid), 32'd0);
    chk("drain_queue", 32'(exp_q.size()), 32'd0);
    chk("drain_rd_ptr", 32'(bus.rd_ptr), 32'd11);

    // Random ready and write rate
    p0 = pop_cnt;
    words = 0;
    cycles = 0;
    while ((words < 1000 || exp_q.size() > 0) && cycles < 30000) begin
      step();
      bus.dout_ready = ($urandom_range(0, 3) != 0);
      if (words < 1000 && !full() && $urandom_range(0, 2) != 0) begin
        write_words(1, 8'($urandom));
        words++;
      end
      cycles++;
    end
    repeat (2) @(negedge clk_B);
    chk("rand_queue", 32'(exp_q.size()), 32'd0);
    chk("rand_pops", 32'(pop_cnt - p0), 32'd1000);

    // Stream 20 words across the pointer wrap
    step();
    bus.dout_ready = 1'b1;
    wrap_seen = 1'b0;
    words = 0;
    cycles = 0;
    while ((words < 20 || exp_q.size() > 0) && cycles < 500) begin
      if (words < 20 && !full()) begin
        write_words(1, 8'hC0 + 8'(words));
        words++;
      end
      step();
      cycles++;
    end
    repeat (2) @(negedge clk_B);
    chk("wrap_seen", 32'(wrap_seen), 32'd1);
    chk("wrap_queue", 32'(exp_q.size()), 32'd0);
    chk("wrap_rd_ptr", 32'(bus.rd_ptr), 32'd7);

    // Reset with the buffer full
    step();
    bus.dout_ready = 1'b0;
    write_words(4, 8'hD0);
    repeat (5) step();
    chk("pre_rst_valid", 32'(bus.dout_valid), 32'd1);
    #1;
    rst = 1'b1;
    wr_ptr = 4'd0;
    exp_q.delete();
    #1;
    chk("arst_valid", 32'(bus.dout_valid), 32'd0);
    chk("arst_dout", 32'(bus.dout), 32'd0);
    chk("arst_rd_en", 32'(bus.mem_rd_en), 32'd0);
    chk("arst_rd_ptr", 32'(bus.rd_ptr), 32'd0);
    chk("arst_g_ptr", 32'(bus.g_rd_ptr), 32'd0);
    repeat (2) step();
    rst = 1'b0;
    step();
    bus.dout_ready = 1'b1;
    p0 = pop_cnt;
    write_words(1, 8'h55);
    cnt = 0;
    while (!bus.dout_valid && cnt < 10) begin
      @(negedge clk_B);
      cnt++;
    end
    chk("post_rst_valid", 32'(bus.dout_valid), 32'd1);
    chk("post_rst_dout", 32'(bus.dout), 32'h55);
    repeat (2) @(negedge clk_B);
    chk("post_rst_pops", 32'(pop_cnt - p0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
